// File: rtl/hc_tx_pkg.sv
// Shared definitions for the host-controller transmit path: SIE control codes,
// requester indices and the port-arbiter state encoding.
package hc_tx_pkg;

  localparam int N_REQ_DEF = 3;

  localparam logic [7:0] TX_PACKET_START  = 8'h02;
  localparam logic [7:0] TX_PACKET_STREAM = 8'h03;
  localparam logic [7:0] TX_PACKET_STOP   = 8'h04;
  localparam logic [7:0] TX_LINE_CTRL     = 8'h06;

  localparam int REQ_DIRECT_CTRL = 0;
  localparam int REQ_SOF         = 1;
  localparam int REQ_SEND_PKT    = 2;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWNED = 2'd1,
    ARB_GAP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/hc_tx_port_arbiter_if.sv
// Requester-side and SIE-side signals of the shared transmit port.
// slave is the arbiter's view; master is the surrounding sources and SIE.
interface hc_tx_port_arbiter_if #(parameter int N_REQ = 3);
  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   reqWEn;
  logic [8*N_REQ-1:0] reqData;
  logic [8*N_REQ-1:0] reqCntl;
  logic [N_REQ-1:0]   reqRdy;
  logic               HCTxPortWEn;
  logic [7:0]         HCTxPortData;
  logic [7:0]         HCTxPortCntl;
  logic               HCTxPortRdy;
  logic               wenViolation;

  modport slave (
    input  req, reqWEn, reqData, reqCntl, HCTxPortRdy,
    output gnt, reqRdy, HCTxPortWEn, HCTxPortData, HCTxPortCntl, wenViolation
  );

  modport master (
    output req, reqWEn, reqData, reqCntl, HCTxPortRdy,
    input  gnt, reqRdy, HCTxPortWEn, HCTxPortData, HCTxPortCntl, wenViolation
  );
endinterface

// File: rtl/hc_prio_enc.sv
// Lowest-set-bit priority encoder; bit 0 has the highest priority.
module hc_prio_enc #(
  parameter  int W  = 3,
  localparam int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  req_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = |req_i;
    for (int i = W - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IW'(i);
    end
  end

endmodule

// File: rtl/hc_tx_port_arbiter.sv
// Fixed-priority, hold-until-release owner of the single SIE transmit port.
// Grant and violation flag are registered; the byte path is combinational.
module hc_tx_port_arbiter
  import hc_tx_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input logic clk,
  input logic rst,
  hc_tx_port_arbiter_if.slave bus
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e       state_q;
  logic [IW-1:0]    owner_q;
  logic [N_REQ-1:0] gnt_q;
  logic             wen_viol_q;

  logic [IW-1:0]    enc_idx;
  logic             enc_valid;
  logic [N_REQ-1:0] enc_oh;
  logic [N_REQ-1:0] owner_oh;
  logic [N_REQ-1:0] stray_wen;
  logic             wen_viol_d;
  logic             port_live;

  logic             port_wen;
  logic [7:0]       port_data;
  logic [7:0]       port_cntl;
  logic [N_REQ-1:0] rdy_fwd;

  hc_prio_enc #(.W(N_REQ)) u_prio_enc (
    .req_i   (bus.req),
    .idx_o   (enc_idx),
    .valid_o (enc_valid)
  );

  assign enc_oh = bus.req & (~bus.req + N_REQ'(1));

  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < N_REQ; i++) owner_oh[i] = (owner_q == IW'(i));
  end

  // Any strobe not from the current owner is dropped and flagged.
  assign stray_wen  = bus.reqWEn & ~((state_q == ARB_OWNED) ? owner_oh : '0);
  assign wen_viol_d = |stray_wen;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      owner_q    <= '0;
      gnt_q      <= '0;
      wen_viol_q <= 1'b0;
    end else begin
      wen_viol_q <= wen_viol_d;
      case (state_q)
        ARB_IDLE: begin
          if (enc_valid) begin
            owner_q <= enc_idx;
            gnt_q   <= enc_oh;
            state_q <= ARB_OWNED;
          end
        end
        ARB_OWNED: begin
          if ((bus.req & owner_oh) == '0) begin
            gnt_q   <= '0;
            state_q <= ARB_GAP;
          end
        end
        ARB_GAP:  state_q <= ARB_IDLE;
        default:  state_q <= ARB_IDLE;
      endcase
    end
  end

  // Gating with rst blanks the port in the same cycle reset is applied.
  assign port_live = (state_q == ARB_OWNED) && !rst;

  always_comb begin
    port_wen  = 1'b0;
    port_data = 8'h00;
    port_cntl = 8'h00;
    rdy_fwd   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (port_live && owner_oh[i]) begin
        port_wen   = bus.reqWEn[i];
        port_data  = bus.reqData[8*i +: 8];
        port_cntl  = bus.reqCntl[8*i +: 8];
        rdy_fwd[i] = bus.HCTxPortRdy;
      end
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.wenViolation = wen_viol_q;
  assign bus.HCTxPortWEn  = port_wen;
  assign bus.HCTxPortData = port_data;
  assign bus.HCTxPortCntl = port_cntl;
  assign bus.reqRdy       = rdy_fwd;

endmodule

// File: tb/tb_hc_tx_port_arbiter.sv
// Directed bench for hc_tx_port_arbiter: inputs change on the falling edge,
// outputs are compared mid-cycle against hand-computed values.
module tb_hc_tx_port_arbiter;
  import hc_tx_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  hc_tx_port_arbiter_if #(.N_REQ(3)) bif ();

  hc_tx_port_arbiter #(.N_REQ(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic chk_port_idle(input string tag);
    chk({tag, "_wen"},  32'(bif.HCTxPortWEn),  32'h0);
    chk({tag, "_data"}, 32'(bif.HCTxPortData), 32'h00);
    chk({tag, "_cntl"}, 32'(bif.HCTxPortCntl), 32'h00);
  endtask

  logic [2:0] rw;
  logic [23:0] rd;
  logic [23:0] rc;

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    bif.req = '0; bif.reqWEn = '0; bif.reqData = '0; bif.reqCntl = '0;
    bif.HCTxPortRdy = 1'b0;
    nxt(); nxt();
    chk("rst_gnt", 32'(bif.gnt), 32'h0);
    chk("rst_viol", 32'(bif.wenViolation), 32'h0);
    chk("rst_rdy", 32'(bif.reqRdy), 32'h0);
    chk_port_idle("rst");
    rst = 1'b0;
    nxt();

    // single request from requester 2
    bif.req = 3'b100;
    #1 chk("single_gnt_t0", 32'(bif.gnt), 32'h0);
    nxt();
    chk("single_gnt_t1", 32'(bif.gnt), 32'b100);
    bif.reqWEn = 3'b100;
    bif.reqData = {8'hA5, 8'h00, 8'h00};
    bif.reqCntl = {TX_PACKET_START, 8'h00, 8'h00};
    bif.HCTxPortRdy = 1'b1;
    #1;
    chk("single_wen", 32'(bif.HCTxPortWEn), 32'h1);
    chk("single_data", 32'(bif.HCTxPortData), 32'hA5);
    chk("single_cntl", 32'(bif.HCTxPortCntl), 32'h02);
    chk("single_rdy1", 32'(bif.reqRdy), 32'b100);
    nxt();
    chk("single_noviol", 32'(bif.wenViolation), 32'h0);
    bif.HCTxPortRdy = 1'b0;
    #1 chk("single_rdy0", 32'(bif.reqRdy), 32'b000);
    bif.reqWEn = '0;
    bif.req = 3'b000;
    nxt();
    chk("single_gap_gnt", 32'(bif.gnt), 32'h0);
    chk_port_idle("single_gap");
    nxt();

    // simultaneous requests resolve by index
    bif.req = 3'b111;
    nxt(); chk("sim_gnt0", 32'(bif.gnt), 32'b001);
    nxt(); chk("sim_hold0", 32'(bif.gnt), 32'b001);
    bif.req = 3'b110;
    nxt(); chk("sim_gap1a", 32'(bif.gnt), 32'b000);
    nxt(); chk("sim_gap1b", 32'(bif.gnt), 32'b000);
    nxt(); chk("sim_gnt1", 32'(bif.gnt), 32'b010);
    bif.req = 3'b100;
    nxt(); chk("sim_gap2a", 32'(bif.gnt), 32'b000);
    nxt(); chk("sim_gap2b", 32'(bif.gnt), 32'b000);
    nxt(); chk("sim_gnt2", 32'(bif.gnt), 32'b100);

    // higher-priority arrival does not pre-empt
    bif.req = 3'b101;
    nxt(); chk("nopre_hold_a", 32'(bif.gnt), 32'b100);
    nxt(); chk("nopre_hold_b", 32'(bif.gnt), 32'b100);
    bif.req = 3'b001;
    nxt(); chk("nopre_gap_a", 32'(bif.gnt), 32'b000);
    nxt(); chk("nopre_gap_b", 32'(bif.gnt), 32'b000);
    nxt(); chk("nopre_gnt0", 32'(bif.gnt), 32'b001);
    bif.req = 3'b000;
    nxt(); nxt(); nxt();

    // non-owner strobe is dropped and flagged once
    bif.req = 3'b100;
    nxt(); chk("viol_gnt", 32'(bif.gnt), 32'b100);
    bif.reqData = {8'h11, 8'hFF, 8'h00};
    bif.reqCntl = {TX_PACKET_STREAM, 8'hFF, 8'h00};
    bif.reqWEn = 3'b010;
    #1;
    chk("viol_wen_drop", 32'(bif.HCTxPortWEn), 32'h0);
    chk("viol_data", 32'(bif.HCTxPortData), 32'h11);
    chk("viol_cntl", 32'(bif.HCTxPortCntl), 32'h03);
    nxt();
    chk("viol_pulse", 32'(bif.wenViolation), 32'h1);
    bif.reqWEn = 3'b100;
    #1;
    chk("viol_owner_wen", 32'(bif.HCTxPortWEn), 32'h1);
    chk("viol_owner_data", 32'(bif.HCTxPortData), 32'h11);
    nxt();
    chk("viol_clear", 32'(bif.wenViolation), 32'h0);
    bif.reqWEn = 3'b110;
    #1 chk("viol_mix_data", 32'(bif.HCTxPortData), 32'h11);
    nxt();
    chk("viol_mix_pulse", 32'(bif.wenViolation), 32'h1);
    bif.reqWEn = 3'b000;
    bif.req = 3'b000;
    nxt();
    chk("viol_mix_clear", 32'(bif.wenViolation), 32'h0);
    nxt(); nxt();

    // reset while requester 1 is mid-transfer
    bif.req = 3'b010;
    nxt(); chk("rmid_gnt", 32'(bif.gnt), 32'b010);
    bif.reqWEn = 3'b010;
    bif.reqData = {8'h00, 8'h5A, 8'h00};
    bif.reqCntl = {8'h00, TX_LINE_CTRL, 8'h00};
    #1;
    chk("rmid_wen", 32'(bif.HCTxPortWEn), 32'h1);
    chk("rmid_cntl", 32'(bif.HCTxPortCntl), 32'h06);
    rst = 1'b1;
    #1 chk_port_idle("rmid_now");
    nxt();
    chk("rmid_gnt_drop", 32'(bif.gnt), 32'b000);
    chk_port_idle("rmid_after");
    bif.reqWEn = 3'b000;
    rst = 1'b0;
    #1 chk_port_idle("rmid_idle");
    nxt(); chk("rmid_regnt", 32'(bif.gnt), 32'b010);
    bif.reqWEn = 3'b010;
    #1 chk("rmid_regnt_data", 32'(bif.HCTxPortData), 32'h5A);
    bif.reqWEn = 3'b000;
    bif.req = 3'b000;
    nxt(); nxt(); nxt();

    // idle port ignores everything but flags each strobe
    for (int k = 0; k < 10; k++) begin
      rw = (k == 0) ? 3'b000 : 3'($urandom_range(0, 7));
      rd = 24'($urandom);
      rc = 24'($urandom);
      bif.reqWEn = rw;
      bif.reqData = rd;
      bif.reqCntl = rc;
      #1 chk_port_idle("idle");
      chk("idle_rdy", 32'(bif.reqRdy), 32'h0);
      nxt();
      chk("idle_viol", 32'(bif.wenViolation), 32'(|rw));
      chk("idle_gnt", 32'(bif.gnt), 32'h0);
    end
    bif.reqWEn = 3'b000;
    nxt();
    chk("idle_viol_end", 32'(bif.wenViolation), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
